fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end: holds the architectural fetch PC, optionally translates it through a single-level PTE lookup, fetches one 32-bit instruction per request over the instruction bus, and buffers fetched `{pc, instr}` pairs in a DEPTH-entry FIFO for decode. It sits between the ibus/PTE-read ports and the decode stage. Compared with the single-register fetch stage it replaces, it adds:
- configurable buffering and backpressure,
- redirect with in-flight kill,
- compile-time optional translation.

## Interface
Parameters:
- `ADDR_W`, 64, width of PC and bus addresses (≥ 57).
- `DEPTH`, 4, FIFO entries (power of two, ≥ 2).
- `PCINIT`, 64'h8000_0000, PC after reset (truncated to ADDR_W).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  branch/jump/exception redirect.
- `redirect_pc`  in  ADDR_W  new fetch PC.
- `trans_on`  in  1  paging enabled.
- `ptw_req`  out  1  PTE read request, held until `ptw_ok`.
- `ptw_vaddr`  out  ADDR_W  virtual PC being translated.
- `ptw_ok`  in  1  PTE read complete.
- `ptw_pte`  in  64  returned PTE.
- `ibus_valid`  out  1  instruction request, held until `ibus_data_ok`.
- `ibus_addr`  out  ADDR_W  physical fetch address.
- `ibus_data_ok`  in  1  instruction returned.
- `ibus_data`  in  32  instruction word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  decode accepts head entry.
- `out_pc`  out  ADDR_W  PC of head entry.
- `out_instr`  out  32  instruction of head entry.

## Operation
State machine: `IDLE`, `TRANS`, `FETCH`. There is at most one outstanding request.

- **IDLE**
  - If `count < DEPTH`: go to `TRANS` when `trans_on`=1, else go to `FETCH` with `paddr = pc`.
  - `trans_on` is sampled only in `IDLE`.
- **TRANS**
  - `ptw_req`=1 and `ptw_vaddr=pc`.
  - On `ptw_ok`: latch `paddr = {pte[54:10], pc[11:0]}`, zero-extended/truncated to ADDR_W; go to `FETCH`.
- **FETCH**
  - `ibus_valid`=1 and `ibus_addr=paddr`.
  - On `ibus_data_ok`: push `{pc, ibus_data}`, set `pc <= pc+4` (mod 2^ADDR_W), go to `IDLE`.
- **FIFO**
  - Head is driven combinationally on `out_*`.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle are both performed.
  - Overflow is impossible: the admission check in `IDLE` holds because `count` cannot rise while a request is outstanding.
- **Redirect** (highest priority)
  - `pc <= redirect_pc`, FIFO flushed (`count <= 0`, pop ignored).
  - In `IDLE`: stay in `IDLE`.
  - In `TRANS`/`FETCH` with the matching ok high in the same cycle: discard the response, go to `IDLE`.
  - In `TRANS`/`FETCH` without the ok: set `kill`. The request stays asserted, unchanged, until its ok arrives. The response is then discarded, with no push and no PC increment, `kill` clears and the state goes to `IDLE`.
  - A second redirect while `kill` is set only updates `pc`.
- **Reset mid-operation:** state returns to `IDLE` unconditionally; any outstanding bus response is ignored by the bus protocol.

## Timing
- **Reset values:** state `IDLE`, `pc=PCINIT`, `count=0`, `kill=0`. Outputs: `ptw_req=0`, `ibus_valid=0`, `out_valid=0`, `out_pc=0`, `out_instr=0`, `ptw_vaddr=PCINIT`, `ibus_addr=0`.
- **Untranslated path:**
  - `ibus_valid` rises 1 cycle after leaving `IDLE`, i.e. cycle 2 after reset release.
  - An `ibus_data_ok` in cycle N gives `out_valid` in cycle N+1.
- **Translated path:** adds one `TRANS` phase (≥1 cycle) before `FETCH`.
- **Throughput:** peak one instruction per 2 cycles with zero-wait bus, untranslated.
- **Redirect:** `out_valid`=0 in the cycle after `redirect_valid`. The first post-redirect `ibus_valid` is ≥1 cycle after `IDLE` is re-entered.

## Configuration
- `FETCH_TRANS_EN` defined:
  - `TRANS` state and `ptw_*` logic are present, as described above.
- `FETCH_TRANS_EN` undefined:
  - `trans_on` and `ptw_ok`/`ptw_pte` are ignored.
  - `ptw_req` is tied to 0 and `ptw_vaddr` is tied to 0.
  - `IDLE` always goes to `FETCH` with `paddr=pc`.
  - The port list is unchanged.

## Test plan
- **Zero-wait fetch:** reset, `trans_on`=0, `ibus_data_ok` always 1, `out_ready`=1 → `ibus_addr` sequence 0x8000_0000, 0x8000_0004, …; `out_pc`/`out_instr` match in order.
- **Backpressure:** `out_ready`=0, DEPTH=4 → exactly 4 pushes, `ibus_valid` stays 0 afterwards. Raising `out_ready` for 1 cycle → exactly one new fetch.
- **Translation:** `trans_on`=1, pc=0x0000_1234, PTE with bits[54:10]=0x80000 → `ptw_vaddr`=0x1234, then `ibus_addr`=0x8000_0234 (`FETCH_TRANS_EN` set). Without the macro → `ibus_addr`=0x1234, `ptw_req` never 1.
- **Redirect with kill:** redirect to 0x8000_1000 while `FETCH` waits 5 cycles for `ibus_data_ok` → the old word is never seen at `out_*`. The next `ibus_addr` is 0x8000_1000 and the FIFO reads empty the cycle after redirect.
- **Simultaneous events:**
  - Redirect in the same cycle as `ibus_data_ok` and a pop → no push, `count`=0, next fetch at `redirect_pc`.
  - Push and pop together with `count`=3 → `count` stays 3.
- **Reset mid-`TRANS`:** assert `reset` while `ptw_req`=1 → next cycle `ptw_req`=0, `pc`=PCINIT, `out_valid`=0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - redirect, PTE-read, instruction-bus and decode-side signals of fetch_queue
interface fetch_queue_if #(
    parameter int ADDR_W = 64
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              trans_on;

    logic              ptw_req;
    logic [ADDR_W-1:0] ptw_vaddr;
    logic              ptw_ok;
    logic [63:0]       ptw_pte;

    logic              ibus_valid;
    logic [ADDR_W-1:0] ibus_addr;
    logic              ibus_data_ok;
    logic [31:0]       ibus_data;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       out_instr;

    modport master (
        input  redirect_valid, redirect_pc, trans_on,
        input  ptw_ok, ptw_pte, ibus_data_ok, ibus_data, out_ready,
        output ptw_req, ptw_vaddr, ibus_valid, ibus_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, trans_on,
        output ptw_ok, ptw_pte, ibus_data_ok, ibus_data, out_ready,
        input  ptw_req, ptw_vaddr, ibus_valid, ibus_addr,
        input  out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC, optional PTE translation (FETCH_TRANS_EN), one-outstanding ibus fetch, DEPTH-entry {pc, instr} FIFO
module fetch_queue #(
    parameter int          ADDR_W = 64,
    parameter int          DEPTH  = 4,
    parameter logic [63:0] PCINIT = 64'h8000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master fq
);
    localparam int                PTR_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(PCINIT);

    typedef enum logic [1:0] {IDLE, TRANS, FETCH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic              kill_q, kill_d;

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [31:0]       instr_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic push, pop, flush, room, trans_en;
    logic unused_ok;

`ifdef FETCH_TRANS_EN
    assign trans_en     = fq.trans_on;
    assign fq.ptw_req   = (state_q == TRANS);
    // vaddr_q freezes the translated PC so a killed request stays unchanged while pc moves.
    assign fq.ptw_vaddr = (state_q == TRANS) ? vaddr_q : pc_q;
    assign unused_ok    = ^{fq.ptw_pte[63:55], fq.ptw_pte[9:0]};
`else
    assign trans_en     = 1'b0;
    assign fq.ptw_req   = 1'b0;
    assign fq.ptw_vaddr = '0;
    assign unused_ok    = ^{fq.trans_on, fq.ptw_ok, fq.ptw_pte, vaddr_q};
`endif

    assign flush = fq.redirect_valid;
    assign room  = (count_q < (PTR_W+1)'(DEPTH));
    assign pop   = (count_q != '0) && fq.out_ready && !flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        paddr_d = paddr_q;
        vaddr_d = vaddr_q;
        kill_d  = kill_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fq.redirect_valid && room) begin
                    if (trans_en) begin
                        state_d = TRANS;
                        vaddr_d = pc_q;
                    end else begin
                        state_d = FETCH;
                        paddr_d = pc_q;
                    end
                end
            end
            TRANS: begin
`ifdef FETCH_TRANS_EN
                if (fq.ptw_ok) begin
                    if (kill_q || fq.redirect_valid) begin
                        state_d = IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = FETCH;
                        paddr_d = ADDR_W'({fq.ptw_pte[54:10], vaddr_q[11:0]});
                    end
                end else if (fq.redirect_valid) begin
                    kill_d = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            FETCH: begin
                if (fq.ibus_data_ok) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (!kill_q && !fq.redirect_valid) begin
                        push = 1'b1;
                        pc_d = pc_q + ADDR_W'(4);
                    end
                end else if (fq.redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Redirect overrides any sequential PC advance.
        if (fq.redirect_valid) pc_d = fq.redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_RST;
            paddr_q  <= '0;
            vaddr_q  <= PC_RST;
            kill_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            paddr_q <= paddr_d;
            vaddr_q <= vaddr_d;
            kill_q  <= kill_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                    2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= fq.ibus_data;
        end
    end

    assign fq.ibus_valid = (state_q == FETCH);
    assign fq.ibus_addr  = paddr_q;
    assign fq.out_valid  = (count_q != '0);
    assign fq.out_pc     = fq.out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign fq.out_instr  = fq.out_valid ? instr_mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - table-driven, directed and randomized model-checked bench for fetch_queue
module tb_fetch_queue;
    localparam int          ADDR_W = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] PCINIT = 64'h8000_0000;
`ifdef FETCH_TRANS_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W)) fq ();

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PCINIT(PCINIT)) dut (
        .clk  (clk),
        .reset(reset),
        .fq   (fq)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    assign fq.ibus_data = mem_word(fq.ibus_addr);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        reset = 1'b1;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc    = '0;
        fq.trans_on       = 1'b0;
        fq.ptw_ok         = 1'b0;
        fq.ptw_pte        = '0;
        fq.ibus_data_ok   = 1'b0;
        fq.out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        if (chk) begin
            check("rst_ptw_req",   fq.ptw_req, 0);
            check("rst_ibus_valid", fq.ibus_valid, 0);
            check("rst_out_valid", fq.out_valid, 0);
            check("rst_out_pc",    fq.out_pc, 0);
            check("rst_out_instr", fq.out_instr, 0);
            check("rst_ibus_addr", fq.ibus_addr, 0);
            check("rst_ptw_vaddr", fq.ptw_vaddr, TR ? PCINIT : 64'h0);
        end
        reset = 1'b0;
    endtask

    task automatic wait_ivalid(input string name);
        int n = 0;
        while (!fq.ibus_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req"}, fq.ibus_valid, 1);
    endtask

    typedef struct packed {
        logic        rdy;
        logic        iv;
        logic [63:0] iaddr;
        logic        ov;
        logic [63:0] opc;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [63:0] q [$];
        logic [63:0] fpc, req_addr, rpc;
        bit          active, stale, just_done, ok, rdy, redir, saw_ptw;
        int          n;

        // Zero-wait bus, DEPTH-limited backpressure, single-cycle release, push+pop at count 3.
        tbl[0]  = '{1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[2]  = '{1'b0, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
        tbl[3]  = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[4]  = '{1'b0, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000};
        tbl[5]  = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[6]  = '{1'b0, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0000};
        tbl[7]  = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[8]  = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[9]  = '{1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[10] = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0004};
        tbl[11] = '{1'b0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0004};
        tbl[12] = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0004};
        tbl[13] = '{1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0004};
        tbl[14] = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0008};
        tbl[15] = '{1'b1, 1'b1, 64'h8000_0014, 1'b1, 64'h8000_0008};
        tbl[16] = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_000C};
        tbl[17] = '{1'b0, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_000C};
        tbl[18] = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_000C};
        tbl[19] = '{1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_000C};

        do_reset(1'b1);
        fq.ibus_data_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_iv", i), fq.ibus_valid, tbl[i].iv);
            if (tbl[i].iv) check($sformatf("tbl%0d_iaddr", i), fq.ibus_addr, tbl[i].iaddr);
            check($sformatf("tbl%0d_ov", i), fq.out_valid, tbl[i].ov);
            check($sformatf("tbl%0d_opc", i), fq.out_pc, tbl[i].opc);
            check($sformatf("tbl%0d_oinstr", i), fq.out_instr, tbl[i].ov ? 64'(mem_word(tbl[i].opc)) : 64'h0);
            fq.out_ready = tbl[i].rdy;
        end

        // Redirect while FETCH waits five cycles: old word dropped, FIFO flushed.
        do_reset(1'b0);
        fq.ibus_data_ok = 1'b1;
        @(negedge clk);
        check("kill_first_addr", fq.ibus_addr, 64'h8000_0000);
        @(negedge clk);
        fq.ibus_data_ok = 1'b0;
        @(negedge clk);
        check("kill_wait_addr", fq.ibus_addr, 64'h8000_0004);
        @(negedge clk);
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 64'h8000_1000;
        @(negedge clk);
        fq.redirect_valid = 1'b0;
        check("kill_flush_ov", fq.out_valid, 0);
        check("kill_hold_iv", fq.ibus_valid, 1);
        check("kill_hold_addr", fq.ibus_addr, 64'h8000_0004);
        @(negedge clk);
        @(negedge clk);
        check("kill_hold2_iv", fq.ibus_valid, 1);
        check("kill_hold2_ov", fq.out_valid, 0);
        fq.ibus_data_ok = 1'b1;
        @(negedge clk);
        fq.ibus_data_ok = 1'b0;
        check("kill_drop_ov", fq.out_valid, 0);
        check("kill_gap_iv", fq.ibus_valid, 0);
        wait_ivalid("kill_next");
        check("kill_next_addr", fq.ibus_addr, 64'h8000_1000);
        fq.ibus_data_ok = 1'b1;
        fq.out_ready    = 1'b1;
        @(negedge clk);
        fq.ibus_data_ok = 1'b0;
        fq.out_ready    = 1'b0;
        check("kill_next_ov", fq.out_valid, 1);
        check("kill_next_pc", fq.out_pc, 64'h8000_1000);
        check("kill_next_instr", fq.out_instr, 64'(mem_word(64'h8000_1000)));

        // Redirect coinciding with ibus_data_ok and a pop.
        @(negedge clk);
        check("sim_addr", fq.ibus_addr, 64'h8000_1004);
        check("sim_iv", fq.ibus_valid, 1);
        fq.ibus_data_ok   = 1'b1;
        fq.out_ready      = 1'b1;
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 64'h8000_2000;
        @(negedge clk);
        fq.ibus_data_ok   = 1'b0;
        fq.out_ready      = 1'b0;
        fq.redirect_valid = 1'b0;
        check("sim_ov", fq.out_valid, 0);
        check("sim_iv_off", fq.ibus_valid, 0);
        wait_ivalid("sim_next");
        check("sim_next_addr", fq.ibus_addr, 64'h8000_2000);
        fq.ibus_data_ok = 1'b1;
        @(negedge clk);
        fq.ibus_data_ok = 1'b0;
        check("sim_next_pc", fq.out_pc, 64'h8000_2000);
        fq.out_ready = 1'b1;
        @(negedge clk);
        fq.out_ready = 1'b0;
        check("sim_count1_ov", fq.out_valid, 0);

        // Translation of pc 0x1234 through a PTE carrying ppn 0x80000 and junk outside [54:10].
        do_reset(1'b0);
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 64'h1234;
        fq.trans_on       = 1'b1;
        @(negedge clk);
        fq.redirect_valid = 1'b0;
        saw_ptw = 1'b0;
        n = 0;
        while (!fq.ibus_valid && n < 20) begin
            if (fq.ptw_req) begin
                saw_ptw = 1'b1;
                check("tr_vaddr", fq.ptw_vaddr, 64'h1234);
                fq.ptw_ok  = 1'b1;
                fq.ptw_pte = 64'hFF00_0000_2000_03FF;
            end else begin
                fq.ptw_ok = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        fq.ptw_ok = 1'b0;
        check("tr_iv", fq.ibus_valid, 1);
        check("tr_addr", fq.ibus_addr, TR ? 64'h8000_0234 : 64'h1234);
        check("tr_saw_ptw", saw_ptw, TR);
        check("tr_ptw_off", fq.ptw_req, 0);
        fq.ibus_data_ok = 1'b1;
        @(negedge clk);
        fq.ibus_data_ok = 1'b0;
        check("tr_out_pc", fq.out_pc, 64'h1234);

        // Reset while the first request (PTE read when translation is built in) is pending.
        do_reset(1'b0);
        fq.trans_on = 1'b1;
        n = 0;
        while (!fq.ptw_req && !fq.ibus_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rm_entry", fq.ptw_req, TR);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fq.trans_on = 1'b0;
        check("rm_ptw_req", fq.ptw_req, 0);
        check("rm_iv", fq.ibus_valid, 0);
        check("rm_ov", fq.out_valid, 0);
        check("rm_vaddr", fq.ptw_vaddr, TR ? PCINIT : 64'h0);
        wait_ivalid("rm_next");
        check("rm_next_addr", fq.ibus_addr, PCINIT);

        // Randomized traffic against an in-order queue model of the fetch stream.
        do_reset(1'b0);
        fpc       = PCINIT;
        active    = 1'b0;
        stale     = 1'b0;
        just_done = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_ov", fq.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("rnd_pc", fq.out_pc, q[0]);
                check("rnd_instr", fq.out_instr, 64'(mem_word(q[0])));
            end
            if (just_done) begin
                check("rnd_gap", fq.ibus_valid, 0);
            end else if (active) begin
                check("rnd_hold_v", fq.ibus_valid, 1);
                check("rnd_hold_a", fq.ibus_addr, req_addr);
            end else if (fq.ibus_valid) begin
                check("rnd_addr", fq.ibus_addr, fpc);
                check("rnd_room", q.size() < DEPTH, 1);
                active   = 1'b1;
                req_addr = fpc;
            end

            ok    = active && ($urandom_range(0, 99) < 45);
            rdy   = ($urandom_range(0, 99) < 50);
            redir = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            else rpc = {$urandom(), $urandom()} & ~64'h3;
            fq.ibus_data_ok   = ok;
            fq.out_ready      = rdy;
            fq.redirect_valid = redir;
            fq.redirect_pc    = rpc;

            just_done = 1'b0;
            if (redir) begin
                q.delete();
                fpc = rpc;
                if (active) begin
                    if (ok) begin
                        active    = 1'b0;
                        stale     = 1'b0;
                        just_done = 1'b1;
                    end else begin
                        stale = 1'b1;
                    end
                end
            end else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (active && ok) begin
                    if (!stale) begin
                        q.push_back(fpc);
                        fpc = fpc + 64'd4;
                    end
                    active    = 1'b0;
                    stale     = 1'b0;
                    just_done = 1'b1;
                end
            end
            @(negedge clk);
        end
        fq.ibus_data_ok   = 1'b0;
        fq.out_ready      = 1'b0;
        fq.redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
